piezo_seq_drv: RTL and testbench

//  Parametrised piezo alert sequencer for the Segway audio path; successor to the

---
 rtl/piezo_seq_drv.sv | 155 +++++++++++++++
 tb/tb_piezo_seq_drv.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_seq_drv.sv
// Piezo alert sequencer: plays a parameter-table tune forward, backward or as a
// short fast loop, with a silent gap between repeats of the full tune.
module piezo_seq_drv #(
  parameter bit                        FAST_SIM   = 1'b0,
  parameter int                        NUM_NOTES  = 6,
  parameter int                        FAST_NOTES = 3,
  parameter int                        REPEAT_CYC = 150_000_000,
  parameter logic [NUM_NOTES*16-1:0]   NOTE_PER   = {16'd15944, 16'd18961, 16'd15944,
                                                     16'd18961, 16'd23889, 16'd31888},
  parameter logic [NUM_NOTES*27-1:0]   NOTE_DUR   = {27'd33554432, 27'd4194304, 27'd12582912,
                                                     27'd8388608, 27'd8388608, 27'd8388608}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_steer,
  input  logic       batt_low,
  input  logic       too_fast,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [26:0] DSTEP     = FAST_SIM ? 27'd64 : 27'd1;
  localparam logic [27:0] GSTEP     = FAST_SIM ? 28'd64 : 28'd1;
  localparam logic [27:0] REP       = 28'(REPEAT_CYC);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_NOTES - 1);
  localparam logic [2:0]  FAST_LAST = 3'(FAST_NOTES - 1);

  state_t             state;
  logic [15:0]        per_cnt;
  logic [26:0]        dur_cnt;
  logic [27:0]        gap_cnt;
  logic [1:0]         req;
  logic [7:0][15:0]   per_tab;
  logic [7:0][26:0]   dur_tab;

  // Unused table slots read as zero so a 3-bit index never leaves the table.
  for (genvar g = 0; g < 8; g++) begin : g_tab
    if (g < NUM_NOTES) begin : g_used
      assign per_tab[g] = NOTE_PER[16*g +: 16];
      assign dur_tab[g] = NOTE_DUR[27*g +: 27];
    end else begin : g_pad
      assign per_tab[g] = '0;
      assign dur_tab[g] = '0;
    end
  end

  always_comb begin
    req = 2'd0;
    if (too_fast)      req = 2'd3;
    else if (batt_low) req = 2'd2;
    else if (en_steer) req = 2'd1;
  end

  function automatic logic [2:0] first_note(input logic [1:0] m);
    return (m == 2'd2) ? LAST_IDX : 3'd0;
  endfunction

  function automatic logic [2:0] last_note(input logic [1:0] m);
    case (m)
      2'd3:    return FAST_LAST;
      2'd2:    return 3'd0;
      default: return LAST_IDX;
    endcase
  endfunction

  logic [15:0] cur_per;
  logic [15:0] half_per;
  logic        note_end;
  logic        gap_end;

  assign cur_per  = per_tab[note_idx];
  assign half_per = {1'b0, cur_per[15:1]};
  assign note_end = (dur_cnt + DSTEP) >= dur_tab[note_idx];
  assign gap_end  = (gap_cnt + GSTEP) >= REP;
  assign busy     = (state != IDLE);
  assign piezo_n  = ~piezo;

  // piezo is registered off the current count, so a fresh note starts low for one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      per_cnt  <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      piezo    <= 1'b0;
      note_idx <= '0;
      mode     <= '0;
    end else begin
      case (state)
        IDLE: begin
          piezo   <= 1'b0;
          per_cnt <= '0;
          dur_cnt <= '0;
          gap_cnt <= '0;
          if (req != 2'd0) begin
            state    <= PLAY;
            mode     <= req;
            note_idx <= first_note(req);
          end
        end
        PLAY: begin
          if (note_end) begin
            piezo   <= 1'b0;
            per_cnt <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            if (req == 2'd0) begin
              state    <= IDLE;
              mode     <= 2'd0;
              note_idx <= 3'd0;
            end else if (req != mode) begin
              mode     <= req;
              note_idx <= first_note(req);
            end else if (note_idx == last_note(mode)) begin
              note_idx <= 3'd0;
              if (mode != 2'd3) state <= GAP;
            end else begin
              note_idx <= (mode == 2'd2) ? note_idx - 3'd1 : note_idx + 3'd1;
            end
          end else begin
            piezo   <= per_cnt < half_per;
            per_cnt <= (per_cnt == cur_per - 16'd1) ? 16'd0 : per_cnt + 16'd1;
            dur_cnt <= dur_cnt + DSTEP;
          end
        end
        GAP: begin
          piezo <= 1'b0;
          if (req == 2'd0) begin
            state   <= IDLE;
            mode    <= 2'd0;
            gap_cnt <= '0;
          end else if (req != mode) begin
            state    <= PLAY;
            mode     <= req;
            note_idx <= first_note(req);
            gap_cnt  <= '0;
          end else if (gap_end) begin
            state    <= PLAY;
            note_idx <= first_note(mode);
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GSTEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_seq_drv.sv
// Bench for piezo_seq_drv: a short 4-note tune with FAST_SIM stepping, compared
// cycle by cycle against a note/gap schedule built from the tune tables.
module tb_piezo_seq_drv;

  localparam int NN  = 4;
  localparam int FN  = 2;
  localparam int PER_T [NN] = '{10, 7, 12, 9};
  localparam int DUR_V [NN] = '{1920, 1280, 1590, 2560};
  localparam int REP = 2559;
  localparam logic [7:0] IDLE_S = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_steer = 1'b0, batt_low = 1'b0, too_fast = 1'b0;
  logic       piezo, piezo_n, busy;
  logic [2:0] note_idx;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  piezo_seq_drv #(
    .FAST_SIM(1'b1), .NUM_NOTES(NN), .FAST_NOTES(FN), .REPEAT_CYC(REP),
    .NOTE_PER({16'd9, 16'd12, 16'd7, 16'd10}),
    .NOTE_DUR({27'd2560, 27'd1590, 27'd1280, 27'd1920})
  ) dut (
    .clk(clk), .rst(rst), .en_steer(en_steer), .batt_low(batt_low), .too_fast(too_fast),
    .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .note_idx(note_idx), .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cyc_of(int v);
    return (v + 63) / 64;
  endfunction

  function automatic logic [7:0] obs();
    return {busy, note_idx, mode, piezo, piezo_n};
  endfunction

  // A note of n clks: first clk silent, then a square wave of its period.
  task automatic push_note(int m, int idx);
    logic p;
    for (int k = 0; k < cyc_of(DUR_V[idx]); k++) begin
      p = (k != 0) && (((k - 1) % PER_T[idx]) < PER_T[idx] / 2);
      exp_q.push_back({1'b1, 3'(idx), 2'(m), p, ~p});
    end
  endtask

  task automatic push_gap(int m);
    for (int k = 0; k < cyc_of(REP); k++) exp_q.push_back({1'b1, 3'd0, 2'(m), 1'b0, 1'b1});
  endtask

  task automatic push_idle(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(IDLE_S);
  endtask

  // Push the first 'count' items (notes or gaps) of mode m's endless sequence.
  task automatic push_mode(int m, int count);
    int pos = 0;
    for (int j = 0; j < count; j++) begin
      if (m != 3 && pos == NN) begin
        push_gap(m);
        pos = 0;
      end else begin
        push_note(m, (m == 2) ? NN - 1 - pos : pos);
        pos++;
        if (m == 3 && pos == FN) pos = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {too_fast, batt_low, en_steer} = 3'b000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 250; c++) begin
      if (c == 200) rst = 1'b0;
      tick();
      n_tests++;
      if (obs() !== IDLE_S) begin
        n_fail++;
        $display("FAIL reset cyc %0d got %b exp %b", c, obs(), IDLE_S);
        break;
      end
    end
  endtask

  task automatic test_steer();
    do_reset();
    push_mode(1, 7);
    en_steer = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL steer cyc %0d got %b exp %b", c, obs(), exp_q[c]);
        break;
      end
    end
  endtask

  task automatic test_batt();
    do_reset();
    push_mode(2, 6);
    batt_low = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL batt cyc %0d got %b exp %b", c, obs(), exp_q[c]);
        break;
      end
    end
  endtask

  task automatic test_fast();
    do_reset();
    push_mode(3, 6);
    {too_fast, en_steer} = 2'b11;
    for (int c = 0; c < exp_q.size(); c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL fast cyc %0d got %b exp %b", c, obs(), exp_q[c]);
        break;
      end
    end
  endtask

  task automatic test_priority();
    logic [2:0] combo;
    int m;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      combo = 3'($urandom_range(1, 7));
      m = combo[2] ? 3 : combo[1] ? 2 : 1;
      push_mode(m, 2);
      {too_fast, batt_low, en_steer} = combo;
      for (int c = 0; c < exp_q.size(); c++) begin
        tick();
        n_tests++;
        if (obs() !== exp_q[c]) begin
          n_fail++;
          $display("FAIL prio in=%b cyc %0d got %b exp %b", combo, c, obs(), exp_q[c]);
          break;
        end
      end
    end
  endtask

  task automatic test_preempt();
    int n0 = cyc_of(DUR_V[0]);
    int n1 = cyc_of(DUR_V[1]);
    int sw, off;
    do_reset();
    push_mode(1, 2);
    push_mode(3, 3);
    push_idle(20);
    sw  = n0 + $urandom_range(1, n1 - 2);
    off = 2 * (n0 + n1) + $urandom_range(0, n0 - 1);
    en_steer = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL preempt cyc %0d sw %0d off %0d got %b exp %b", c, sw, off, obs(), exp_q[c]);
        break;
      end
      if (c == sw) too_fast = 1'b1;
      if (c == off) {too_fast, en_steer} = 2'b00;
    end
  endtask

  task automatic test_rst_mid();
    int stop;
    do_reset();
    push_mode(1, 4);
    stop = cyc_of(DUR_V[0]) + cyc_of(DUR_V[1]) + cyc_of(DUR_V[2]) + 1 + PER_T[3] * $urandom_range(0, 2);
    en_steer = 1'b1;
    for (int c = 0; c <= stop; c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL rst_pre cyc %0d got %b exp %b", c, obs(), exp_q[c]);
        break;
      end
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs() !== IDLE_S) begin
      n_fail++;
      $display("FAIL rst_async got %b exp %b", obs(), IDLE_S);
    end
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    push_mode(1, 2);
    for (int c = 0; c < exp_q.size(); c++) begin
      tick();
      n_tests++;
      if (obs() !== exp_q[c]) begin
        n_fail++;
        $display("FAIL rst_restart cyc %0d got %b exp %b", c, obs(), exp_q[c]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_steer();
    test_batt();
    test_fast();
    test_priority();
    test_preempt();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
